// File: rtl/dehaze_pkg.sv
// Shared constants and divider state type for the dehaze transmission stage.
package dehaze_pkg;

    localparam logic [7:0]  OMEGA_DEF   = 8'd243;
    localparam logic [7:0]  T0_MIN_DEF  = 8'd26;
    localparam logic [7:0]  A_RESET_DEF = 8'd230;
    localparam logic [15:0] RECIP_RESET = 16'd284;
    localparam int          DIV_ITER    = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/recip_divider.sv
// Sequential restoring divider producing floor(65535 / divisor), one quotient bit per cycle.
module recip_divider
    import dehaze_pkg::*;
#(
    parameter logic [7:0] A_RESET = A_RESET_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient
);

    div_state_e  state_q, state_d;
    logic [7:0]  divisor_q, divisor_d;
    logic [7:0]  rem_q, rem_d;
    logic [15:0] quot_q, quot_d;
    logic [3:0]  iter_q, iter_d;
    logic [8:0]  trial;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            divisor_q <= A_RESET;
            rem_q     <= '0;
            quot_q    <= '0;
            iter_q    <= '0;
        end else begin
            state_q   <= state_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            iter_q    <= iter_d;
        end
    end

    // The all-ones dividend shifts out of quot_q's MSB while quotient bits shift in at the LSB.
    always_comb begin
        state_d   = state_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        iter_d    = iter_q;
        trial     = {rem_q, quot_q[15]};
        if (start) begin
            state_d   = DIV;
            divisor_d = divisor;
            rem_d     = '0;
            quot_d    = 16'hFFFF;
            iter_d    = '0;
        end else begin
            case (state_q)
                DIV: begin
                    if (trial >= {1'b0, divisor_q}) begin
                        rem_d  = 8'(trial - {1'b0, divisor_q});
                        quot_d = {quot_q[14:0], 1'b1};
                    end else begin
                        rem_d  = trial[7:0];
                        quot_d = {quot_q[14:0], 1'b0};
                    end
                    iter_d = iter_q + 4'd1;
                    if (iter_q == 4'(DIV_ITER - 1)) begin
                        state_d = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy     = (state_q == DIV) || (state_q == DONE);
    assign done     = (state_q == DONE);
    assign quotient = quot_q;

endmodule

// File: rtl/calculate_transmission.sv
// Dehaze transmission estimate t = 1 - omega * dark / A, using a frame-synchronous reciprocal of A.
module calculate_transmission
    import dehaze_pkg::*;
#(
    parameter logic [7:0] OMEGA   = OMEGA_DEF,
    parameter logic [7:0] T0_MIN  = T0_MIN_DEF,
    parameter logic [7:0] A_RESET = A_RESET_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic       per_frame_clken,
    input  logic [7:0] per_img,
    input  logic [7:0] a_value,
    input  logic       a_valid,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic [7:0] post_result,
    output logic       recip_busy
);

    logic        div_done;
    logic [15:0] div_quotient;
    logic [7:0]  a_eff;

    logic        vsync_prev_q, vsync_prev_d;
    logic        pending_q, pending_d;
    logic [15:0] shadow_q, shadow_d;
    logic [15:0] active_q, active_d;
    logic [15:0] ratio_q, ratio_d;
    logic [15:0] prod_q, prod_d;
    logic [7:0]  result_q, result_d;
    logic [2:0]  vsync_dly_q, vsync_dly_d;
    logic [2:0]  href_dly_q, href_dly_d;
    logic [2:0]  clken_dly_q, clken_dly_d;
    logic [7:0]  traw;

    assign a_eff = (a_value == 8'd0) ? 8'd1 : a_value;

    recip_divider #(
        .A_RESET (A_RESET)
    ) u_recip_divider (
        .clk      (clk),
        .rst      (rst),
        .start    (a_valid),
        .divisor  (a_eff),
        .busy     (recip_busy),
        .done     (div_done),
        .quotient (div_quotient)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_prev_q <= 1'b0;
            pending_q    <= 1'b0;
            shadow_q     <= RECIP_RESET;
            active_q     <= RECIP_RESET;
            ratio_q      <= '0;
            prod_q       <= '0;
            result_q     <= '0;
            vsync_dly_q  <= '0;
            href_dly_q   <= '0;
            clken_dly_q  <= '0;
        end else begin
            vsync_prev_q <= vsync_prev_d;
            pending_q    <= pending_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            ratio_q      <= ratio_d;
            prod_q       <= prod_d;
            result_q     <= result_d;
            vsync_dly_q  <= vsync_dly_d;
            href_dly_q   <= href_dly_d;
            clken_dly_q  <= clken_dly_d;
        end
    end

    // A commit at the vsync edge reads the old shadow, so a same-cycle completion waits for the next frame.
    always_comb begin
        vsync_prev_d = per_frame_vsync;
        pending_d    = pending_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        if (per_frame_vsync && !vsync_prev_q && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (div_done && !a_valid) begin
            shadow_d  = div_quotient;
            pending_d = 1'b1;
        end

        ratio_d = 16'(({16'd0, per_img} * {8'd0, active_q}) >> 8);
        prod_d  = 16'(({8'd0, ratio_q} * {16'd0, OMEGA}) >> 8);
        traw    = (prod_q > 16'd255) ? 8'd0 : 8'(16'd255 - prod_q);

        result_d = result_q;
        if (href_dly_q[1] && clken_dly_q[1]) begin
            result_d = (traw < T0_MIN) ? T0_MIN : traw;
        end

        vsync_dly_d = {vsync_dly_q[1:0], per_frame_vsync};
        href_dly_d  = {href_dly_q[1:0], per_frame_href};
        clken_dly_d = {clken_dly_q[1:0], per_frame_clken};
    end

    assign post_frame_vsync = vsync_dly_q[2];
    assign post_frame_href  = href_dly_q[2];
    assign post_frame_clken = clken_dly_q[2];
    assign post_result      = result_q;

endmodule

// File: tb/tb_calculate_transmission.sv
// Self-checking bench for calculate_transmission: directed corner sequences, a vector table and random frames.
module tb_calculate_transmission;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vs = 1'b0;
    logic       hr = 1'b0;
    logic       ck = 1'b0;
    logic       aValid = 1'b0;
    logic [7:0] img = 8'd0;
    logic [7:0] aValue = 8'd0;
    logic       postVs, postHr, postCk, busy;
    logic [7:0] postResult;

    typedef struct {
        logic v;
        logic h;
        logic c;
        int   p;
        int   recip;
    } pixRec_t;

    typedef struct {
        logic [7:0] img;
        logic [7:0] expResult;
    } vec_t;

    pixRec_t hist [3];
    vec_t    vecs [10];
    int      modelRecip, pendValue, divValue, divEnd, modelPost, cycleNo;
    bit      pendValid, divActive, prevVs;
    int      testsRun = 0;
    int      failures = 0;
    int      busyRun;
    logic [7:0] randA;

    calculate_transmission dut (
        .clk              (clk),
        .rst              (rst),
        .per_frame_vsync  (vs),
        .per_frame_href   (hr),
        .per_frame_clken  (ck),
        .per_img          (img),
        .a_value          (aValue),
        .a_valid          (aValid),
        .post_frame_vsync (postVs),
        .post_frame_href  (postHr),
        .post_frame_clken (postCk),
        .post_result      (postResult),
        .recip_busy       (busy)
    );

    always #5 clk = ~clk;

    // Transmission for one pixel straight from the defining formula.
    function automatic int refResult(input int p, input int r);
        int ratio, prod, t;
        ratio = (p * r) / 256;
        prod  = (ratio * 243) / 256;
        t     = 255 - ((prod > 255) ? 255 : prod);
        return (t < 26) ? 26 : t;
    endfunction

    // Transaction-level model: a division finishes 17 cycles after its request, commits on the next vsync rise.
    task automatic modelEdge();
        pixRec_t rec;
        bit rise;
        if (rst) begin
            for (int k = 0; k < 3; k++) hist[k] = '{1'b0, 1'b0, 1'b0, 0, 0};
            modelPost  = 0;
            modelRecip = 284;
            pendValid  = 0;
            divActive  = 0;
            prevVs     = 0;
        end else begin
            rise   = vs && !prevVs;
            prevVs = vs;
            rec    = '{vs, hr, ck, int'(img), modelRecip};
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = rec;
            if (hist[2].h && hist[2].c) modelPost = refResult(hist[2].p, hist[2].recip);
            if (rise && pendValid) begin
                modelRecip = pendValue;
                pendValid  = 0;
            end
            if (divActive && cycleNo == divEnd && !aValid) begin
                pendValue = divValue;
                pendValid = 1;
                divActive = 0;
            end
            if (aValid) begin
                divActive = 1;
                divEnd    = cycleNo + 17;
                divValue  = 65535 / ((aValue == 8'd0) ? 1 : int'(aValue));
            end
        end
        cycleNo++;
    endtask

    task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleNo);
        end
    endtask

    task automatic checkOutput();
        checkVal("post_sync", 32'({postVs, postHr, postCk}), 32'({hist[2].v, hist[2].h, hist[2].c}));
        checkVal("post_result_model", 32'(postResult), 32'(modelPost));
        checkVal("recip_busy_model", 32'(busy), 32'(divActive));
    endtask

    task automatic applyStimulus(input logic v, input logic h, input logic c, input logic [7:0] p,
                                 input logic av, input logic [7:0] a);
        vs = v; hr = h; ck = c; img = p; aValid = av; aValue = a;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
    endtask

    task automatic idle(input int n, input logic v);
        for (int k = 0; k < n; k++) applyStimulus(v, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
    endtask

    // One valid pixel, then two idle cycles so post_result holds that pixel's result.
    task automatic expectPixel(input string name, input logic [7:0] p, input logic v, input int exp);
        applyStimulus(v, 1'b1, 1'b1, p, 1'b0, 8'd0);
        idle(2, v);
        checkVal(name, 32'(postResult), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = '{8'd0,   8'd255};
        vecs[1] = '{8'd0,   8'd255};
        vecs[2] = '{8'd115, 8'd135};
        vecs[3] = '{8'd230, 8'd26};
        vecs[4] = '{8'd255, 8'd26};
        vecs[5] = '{8'd50,  8'd203};
        vecs[6] = '{8'd10,  8'd245};
        vecs[7] = '{8'd20,  8'd235};
        vecs[8] = '{8'd1,   8'd255};
        vecs[9] = '{8'd0,   8'd255};
        cycleNo = 0;

        rst = 1'b1;
        idle(3, 1'b0);
        rst = 1'b0;
        checkVal("reset_post_result", 32'(postResult), 32'd0);
        checkVal("reset_busy", 32'(busy), 32'd0);
        checkVal("reset_post_sync", 32'({postVs, postHr, postCk}), 32'd0);

        // Default A: table of pixels streamed back to back within one frame.
        idle(2, 1'b0);
        idle(1, 1'b1);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 1'(i < 10), 1'(i < 10), (i < 10) ? vecs[i].img : 8'd0, 1'b0, 8'd0);
            if (i >= 2) checkVal("table_result", 32'(postResult), 32'(vecs[i - 2].expResult));
        end

        // New A in blanking: old reciprocal until the next vsync rise.
        idle(2, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'd200);
        idle(20, 1'b0);
        expectPixel("a200_before_commit", 8'd50, 1'b0, 203);
        idle(1, 1'b1);
        expectPixel("a200_after_commit", 8'd50, 1'b1, 196);

        // Restart: second request eight cycles after the first wins.
        idle(2, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'd200);
        idle(7, 1'b0);
        checkVal("busy_before_restart", 32'(busy), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'd100);
        busyRun = 1;
        for (int k = 0; k <= 40; k++) begin
            if (!busy) break;
            if (k == 40) begin
                busyRun = -1;
                break;
            end
            busyRun++;
            idle(1, 1'b0);
        end
        checkVal("busy_run_length", 32'(busyRun), 32'd18);
        idle(2, 1'b0);
        idle(1, 1'b1);
        expectPixel("restart_a100", 8'd50, 1'b1, 135);

        // A of zero is treated as one.
        idle(2, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'd0);
        idle(20, 1'b0);
        idle(1, 1'b1);
        expectPixel("a0_pix1", 8'd1, 1'b1, 26);
        expectPixel("a0_pix0", 8'd0, 1'b1, 255);

        // Commit and new request on the same vsync rise; no mid-frame change.
        idle(2, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'd100);
        idle(20, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 8'd200);
        idle(1, 1'b1);
        expectPixel("same_edge_old_shadow", 8'd50, 1'b1, 135);
        idle(25, 1'b1);
        expectPixel("same_edge_frame_stable", 8'd50, 1'b1, 135);
        idle(2, 1'b0);
        idle(1, 1'b1);
        expectPixel("same_edge_next_frame", 8'd50, 1'b1, 196);

        // Reset in the middle of a division.
        idle(2, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'd200);
        idle(10, 1'b0);
        rst = 1'b1;
        idle(1, 1'b0);
        checkVal("mid_div_reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        idle(25, 1'b0);
        idle(1, 1'b1);
        expectPixel("after_reset_recip", 8'd115, 1'b1, 135);

        // Random frames against the model.
        for (int f = 0; f < 6; f++) begin
            randA = (f == 2) ? 8'd0 : 8'($urandom_range(0, 255));
            idle(3, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, randA);
            idle(22, 1'b0);
            idle(1, 1'b1);
            for (int k = 0; k < 48; k++) begin
                applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              8'($urandom_range(0, 255)), 1'($urandom_range(0, 19) == 0),
                              8'($urandom_range(0, 255)));
            end
        end
        idle(4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
